uart_tx_arbiter: RTL



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and frame-timing helpers for the uart tx arbiter
package uart_pkg;

  localparam int FRAME_BITS_DEFAULT   = 10;
  localparam int GUARD_CYCLES_DEFAULT = 2;

  typedef logic [0:7] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // One frame on the wire plus the trailing idle guard, in clock cycles.
  function automatic int frame_cycles(input int clks_per_bit, input int frame_bits,
                                      input int guard_cycles);
    return clks_per_bit * frame_bits + guard_cycles;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin pick: first asserted
// request at or above the pointer, wrapping modulo NUM_REQ
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [0:NUM_REQ-1] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        winner = PTR_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one uart transmitter among NUM_REQ byte producers,
// holding off further grants for a full frame since the transmitter has no busy flag
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int CLKS_PER_BIT = 87,
  parameter int FRAME_BITS   = FRAME_BITS_DEFAULT,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [0:NUM_REQ-1]   i_req,
  input  logic [0:8*NUM_REQ-1] i_data,
  output logic [0:NUM_REQ-1]   o_ack,
  output logic [0:7]           o_uart_data,
  output logic                 o_start_uart,
  output logic                 o_busy
);

  localparam int FRAME_CYCLES = frame_cycles(CLKS_PER_BIT, FRAME_BITS, GUARD_CYCLES);
  localparam int CNT_W        = $clog2(FRAME_CYCLES);
  localparam int PTR_W        = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_WAIT  = WAIT;

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] pick;
  logic             pick_valid;
  logic [CNT_W-1:0] cnt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (i_req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      winner       <= '0;
      cnt          <= '0;
      o_ack        <= '0;
      o_uart_data  <= 8'h00;
      o_start_uart <= 1'b0;
    end else begin
      o_start_uart <= 1'b0;
      o_ack        <= '0;
      case (state)
        ST_IDLE: begin
          // Strobe and ack are registered here so they land with the stable byte.
          if (pick_valid) begin
            winner       <= pick;
            o_uart_data  <= i_data[8*pick +: 8];
            o_start_uart <= 1'b1;
            o_ack[pick]  <= 1'b1;
            state        <= ST_START;
          end
        end
        ST_START: begin
          ptr   <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          cnt   <= CNT_W'(FRAME_CYCLES - 1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule
